// File: rtl/game_state_ctrl.sv
// game_state_ctrl: frame-driven game supervisor for the penguin runner.
// Tracks the game phase, score, lives, the post-hit grace timer and the frame count.
// Every per-frame update happens on the rising edge of i_v_sync and shows on the outputs one cycle later.
module game_state_ctrl #(
    parameter int LIVES_INIT    = 3,     // lives at game start (fits o_lives)
    parameter int GAME_FRAMES   = 3600,  // PLAYING frames until the game finishes (fits o_frame_cnt)
    parameter int INVULN_FRAMES = 120,   // grace frames after a non-lethal hit
    parameter int SCORE_MAX     = 9999   // score saturation value
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_v_sync,
    input  logic        i_de,
    input  logic        i_penguin_hit,
    input  logic [3:0]  i_obstacle_hit,
    input  logic [3:0]  i_crushed,
    input  logic        i_start,
    output logic        o_is_dead,
    output logic        o_is_finished,
    output logic [1:0]  o_state,
    output logic [15:0] o_score,
    output logic [1:0]  o_lives,
    output logic        o_invuln,
    output logic [11:0] o_frame_cnt
);

    // Grace timer is just wide enough to hold INVULN_FRAMES.
    localparam int TW = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PLAYING  = 2'd1,
        ST_DEAD     = 2'd2,
        ST_FINISHED = 2'd3
    } state_t;

    // Number of obstacles whose crushed level just rose.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    state_t          state_q,   state_d;
    logic   [15:0]   score_q,   score_d;
    logic   [1:0]    lives_q,   lives_d;
    logic   [11:0]   frame_q,   frame_d;
    logic   [TW-1:0] timer_q,   timer_d;
    logic            coll_q,    coll_d;
    logic   [3:0]    crushed_q, crushed_d;
    logic            v_sync_q;

    logic            fe;
    logic            coll_term;
    logic            hit_now;
    logic   [1:0]    lives_dec;
    logic            lethal;
    logic   [2:0]    crush_inc;
    logic   [16:0]   score_sum;
    logic   [15:0]   score_sat;
    logic   [11:0]   frame_inc;

    // Frame boundary and the per-pixel collision term.
    assign fe        = i_v_sync & ~v_sync_q;
    assign coll_term = i_de & i_penguin_hit & (|i_obstacle_hit);

    // A flagged hit only costs a life outside the grace period; the lives guard keeps the counter from wrapping.
    assign hit_now   = coll_q && (timer_q == '0) && (lives_q != 2'd0);
    assign lives_dec = lives_q - 2'd1;
    assign lethal    = hit_now && (lives_dec == 2'd0);

    // Score grows by new crushes only, computed one bit wider so the cap is reached instead of wrapping.
    assign crush_inc = popcount4(i_crushed & ~crushed_q);
    assign score_sum = {1'b0, score_q} + {14'd0, crush_inc};
    assign score_sat = (score_sum >= 17'(SCORE_MAX)) ? 16'(SCORE_MAX) : score_sum[15:0];
    assign frame_inc = frame_q + 12'd1;

    // Next-state and next-counter logic for the game FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        score_d   = score_q;
        lives_d   = lives_q;
        frame_d   = frame_q;
        timer_d   = timer_q;
        // Within a frame the flag accumulates; on the frame edge it restarts with that cycle's term,
        // so a hit in the edge cycle counts toward the new frame.
        coll_d    = fe ? coll_term : (coll_q | coll_term);
        // Crush history follows every frame edge in every state, so a restart never scores stale crushes.
        crushed_d = fe ? i_crushed : crushed_q;

        unique case (state_q)
            ST_IDLE: begin
                // A start that lands on a frame edge begins the game; that edge does no play update.
                if (i_start) begin
                    state_d = ST_PLAYING;
                    score_d = '0;
                    lives_d = 2'(LIVES_INIT);
                    frame_d = '0;
                    timer_d = '0;
                    coll_d  = 1'b0;
                end
            end

            ST_PLAYING: begin
                // i_start is ignored here; counters only move on frame edges.
                if (fe) begin
                    if (hit_now) begin
                        lives_d = lives_dec;
                        if (lives_dec == 2'd0) begin
                            state_d = ST_DEAD;
                        end else begin
                            timer_d = TW'(INVULN_FRAMES);
                        end
                    end else if (timer_q != '0) begin
                        timer_d = timer_q - TW'(1);
                    end
                    score_d = score_sat;
                    frame_d = frame_inc;
                    // Dying on the last frame takes precedence over finishing.
                    if (!lethal && (frame_inc == 12'(GAME_FRAMES))) begin
                        state_d = ST_FINISHED;
                    end
                end
            end

            ST_DEAD, ST_FINISHED: begin
                // Results stay frozen for display; a start goes back to IDLE first.
                if (i_start) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers with synchronous reset; reset wins over a coincident frame edge.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (i_rst) begin
            state_q   <= ST_IDLE;
            score_q   <= '0;
            lives_q   <= 2'(LIVES_INIT);
            frame_q   <= '0;
            timer_q   <= '0;
            coll_q    <= 1'b0;
            crushed_q <= '0;
            v_sync_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            frame_q   <= frame_d;
            timer_q   <= timer_d;
            coll_q    <= coll_d;
            crushed_q <= crushed_d;
            v_sync_q  <= i_v_sync;
        end
    end

    assign o_state       = state_q;
    assign o_is_dead     = (state_q == ST_DEAD);
    assign o_is_finished = (state_q == ST_IDLE) || (state_q == ST_FINISHED);
    assign o_score       = score_q;
    assign o_lives       = lives_q;
    assign o_invuln      = (timer_q != '0);
    assign o_frame_cnt   = frame_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: three differently parameterised copies of game_state_ctrl share one stimulus.
// A: defaults; B: one life, 5-frame game; C: 4 grace frames, score cap 13.
module tb_game_state_ctrl;

    localparam int P_LI [3] = '{3, 1, 3};
    localparam int P_GF [3] = '{3600, 5, 3600};
    localparam int P_INV[3] = '{120, 120, 4};
    localparam int P_SM [3] = '{9999, 9999, 13};

    logic       i_clk = 1'b0;
    logic       rst = 1'b0, vs = 1'b0, de = 1'b0, ph = 1'b0, start = 1'b0;
    logic [3:0] obs = 4'h0, cr = 4'h0;

    logic        dead_a, fin_a, inv_a, dead_b, fin_b, inv_b, dead_c, fin_c, inv_c;
    logic [1:0]  st_a, lv_a, st_b, lv_b, st_c, lv_c;
    logic [15:0] sc_a, sc_b, sc_c;
    logic [11:0] fc_a, fc_b, fc_c;

    int n_checks = 0;
    int n_err    = 0;

    always #5 i_clk = ~i_clk;

    game_state_ctrl u_a (
        .i_clk(i_clk), .i_rst(rst), .i_v_sync(vs), .i_de(de), .i_penguin_hit(ph),
        .i_obstacle_hit(obs), .i_crushed(cr), .i_start(start),
        .o_is_dead(dead_a), .o_is_finished(fin_a), .o_state(st_a), .o_score(sc_a),
        .o_lives(lv_a), .o_invuln(inv_a), .o_frame_cnt(fc_a)
    );

    game_state_ctrl #(.LIVES_INIT(1), .GAME_FRAMES(5)) u_b (
        .i_clk(i_clk), .i_rst(rst), .i_v_sync(vs), .i_de(de), .i_penguin_hit(ph),
        .i_obstacle_hit(obs), .i_crushed(cr), .i_start(start),
        .o_is_dead(dead_b), .o_is_finished(fin_b), .o_state(st_b), .o_score(sc_b),
        .o_lives(lv_b), .o_invuln(inv_b), .o_frame_cnt(fc_b)
    );

    game_state_ctrl #(.INVULN_FRAMES(4), .SCORE_MAX(13)) u_c (
        .i_clk(i_clk), .i_rst(rst), .i_v_sync(vs), .i_de(de), .i_penguin_hit(ph),
        .i_obstacle_hit(obs), .i_crushed(cr), .i_start(start),
        .o_is_dead(dead_c), .o_is_finished(fin_c), .o_state(st_c), .o_score(sc_c),
        .o_lives(lv_c), .o_invuln(inv_c), .o_frame_cnt(fc_c)
    );

    // Reference model: game phase as an int (0 idle, 1 playing, 2 dead, 3 finished), counters as plain ints.
    typedef struct {
        int         state;
        int         score;
        int         lives;
        int         frame;
        int         timer;
        bit         flag;
        logic [3:0] crq;
        bit         vq;
    } model_t;

    model_t mdl[3];

    typedef struct {
        bit         start;
        int         frames;
        bit         hit;
        logic [3:0] cr;
        int         st;
        int         lv;
        int         sc;
        int         fc;
        bit         inv;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic string iname(input int k);
        return (k == 0) ? "A" : (k == 1) ? "B" : "C";
    endfunction

    // One clock of game rules applied to the current inputs.
    function automatic model_t model_next(input model_t m, input int k);
        model_t n;
        bit     fe;
        bit     term;
        bit     died;
        int     s;
        n = m;
        if (rst) begin
            n.state = 0; n.score = 0; n.lives = P_LI[k]; n.frame = 0;
            n.timer = 0; n.flag = 1'b0; n.crq = 4'h0; n.vq = 1'b0;
            return n;
        end
        fe   = vs && !m.vq;
        term = de && ph && (obs != 4'h0);
        n.vq = vs;
        if (fe) n.crq = cr;
        n.flag = fe ? term : (m.flag || term);
        died = 1'b0;
        case (m.state)
            0: if (start) begin
                n.state = 1; n.score = 0; n.lives = P_LI[k]; n.frame = 0;
                n.timer = 0; n.flag = 1'b0;
            end
            1: if (fe) begin
                if (m.flag && m.timer == 0 && m.lives > 0) begin
                    n.lives = m.lives - 1;
                    if (n.lives == 0) died = 1'b1;
                    else              n.timer = P_INV[k];
                end else if (m.timer > 0) begin
                    n.timer = m.timer - 1;
                end
                s = m.score + $countones(cr & ~m.crq);
                n.score = (s > P_SM[k]) ? P_SM[k] : s;
                n.frame = m.frame + 1;
                if (died)                   n.state = 2;
                else if (n.frame == P_GF[k]) n.state = 3;
            end
            default: if (start) n.state = 0;
        endcase
        return n;
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            int a_st, a_sc, a_lv, a_fc, a_inv, a_dead, a_fin;
            case (k)
                0: begin a_st = int'(st_a); a_sc = int'(sc_a); a_lv = int'(lv_a); a_fc = int'(fc_a);
                         a_inv = int'(inv_a); a_dead = int'(dead_a); a_fin = int'(fin_a); end
                1: begin a_st = int'(st_b); a_sc = int'(sc_b); a_lv = int'(lv_b); a_fc = int'(fc_b);
                         a_inv = int'(inv_b); a_dead = int'(dead_b); a_fin = int'(fin_b); end
                default: begin a_st = int'(st_c); a_sc = int'(sc_c); a_lv = int'(lv_c); a_fc = int'(fc_c);
                         a_inv = int'(inv_c); a_dead = int'(dead_c); a_fin = int'(fin_c); end
            endcase
            check($sformatf("%s.model.state @%0t", iname(k), $time), a_st, mdl[k].state);
            check($sformatf("%s.model.score @%0t", iname(k), $time), a_sc, mdl[k].score);
            check($sformatf("%s.model.lives @%0t", iname(k), $time), a_lv, mdl[k].lives);
            check($sformatf("%s.model.frame @%0t", iname(k), $time), a_fc, mdl[k].frame);
            check($sformatf("%s.model.invuln @%0t", iname(k), $time), a_inv, int'(mdl[k].timer != 0));
            check($sformatf("%s.model.dead @%0t", iname(k), $time), a_dead, int'(mdl[k].state == 2));
            check($sformatf("%s.model.finished @%0t", iname(k), $time), a_fin,
                  int'(mdl[k].state == 0 || mdl[k].state == 3));
        end
    endtask

    // Advance one clock: model predicts, DUTs sample, outputs compared 1 ns after the edge.
    task automatic step();
        for (int k = 0; k < 3; k++) mdl[k] = model_next(mdl[k], k);
        @(posedge i_clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; vs = 1'b0; de = 1'b0; ph = 1'b0; obs = 4'h0; start = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // One video frame: three low cycles (optional collision pixel, plus non-qualified near-misses), two high.
    task automatic frame(input bit hit, input logic [3:0] crushed);
        cr = crushed;
        vs = 1'b0; de = 1'b1; ph = 1'b1; obs = hit ? 4'b0010 : 4'b0000;
        step();
        de = 1'b0; ph = 1'b0; obs = 4'b1111;
        step();
        obs = 4'h0;
        step();
        vs = 1'b1;
        step();
        step();
    endtask

    task automatic check_a(input string tag, input int e_st, input int e_lv, input int e_sc,
                           input int e_fc, input int e_inv);
        check({tag, ".state"},    int'(st_a),   e_st);
        check({tag, ".lives"},    int'(lv_a),   e_lv);
        check({tag, ".score"},    int'(sc_a),   e_sc);
        check({tag, ".frame"},    int'(fc_a),   e_fc);
        check({tag, ".invuln"},   int'(inv_a),  e_inv);
        check({tag, ".dead"},     int'(dead_a), int'(e_st == 2));
        check({tag, ".finished"}, int'(fin_a),  int'(e_st == 0 || e_st == 3));
    endtask

    initial begin
        //            start  frames hit   crushed    st lv sc  fc   inv
        tbl[0]  = '{1'b1, 10,  1'b0, 4'b0000,   1, 3, 0, 10,  1'b0};
        tbl[1]  = '{1'b0, 1,   1'b1, 4'b0000,   1, 2, 0, 11,  1'b1};
        tbl[2]  = '{1'b0, 119, 1'b1, 4'b0000,   1, 2, 0, 130, 1'b1};
        tbl[3]  = '{1'b0, 1,   1'b1, 4'b0000,   1, 2, 0, 131, 1'b0};
        tbl[4]  = '{1'b0, 1,   1'b0, 4'b0000,   1, 2, 0, 132, 1'b0};
        tbl[5]  = '{1'b0, 3,   1'b0, 4'b0101,   1, 2, 2, 135, 1'b0};
        tbl[6]  = '{1'b0, 1,   1'b0, 4'b0000,   1, 2, 2, 136, 1'b0};
        tbl[7]  = '{1'b0, 1,   1'b0, 4'b1111,   1, 2, 6, 137, 1'b0};
        tbl[8]  = '{1'b0, 1,   1'b1, 4'b0000,   1, 1, 6, 138, 1'b1};
        tbl[9]  = '{1'b0, 120, 1'b0, 4'b0000,   1, 1, 6, 258, 1'b0};
        tbl[10] = '{1'b0, 1,   1'b1, 4'b0000,   2, 0, 6, 259, 1'b0};
        tbl[11] = '{1'b0, 5,   1'b0, 4'b1111,   2, 0, 6, 259, 1'b0};
        tbl[12] = '{1'b1, 0,   1'b0, 4'b1111,   0, 0, 6, 259, 1'b0};
        tbl[13] = '{1'b1, 2,   1'b0, 4'b1111,   1, 3, 0, 2,   1'b0};
        tbl[14] = '{1'b1, 1,   1'b0, 4'b0000,   1, 3, 0, 3,   1'b0};

        for (int k = 0; k < 3; k++) begin
            mdl[k] = '{state: 0, score: 0, lives: P_LI[k], frame: 0, timer: 0,
                       flag: 1'b0, crq: 4'h0, vq: 1'b0};
        end

        do_reset();
        check_a("reset", 0, 3, 0, 0, 0);

        // Directed game on A: idle frames, grace period, crush scoring, three lives lost, restart.
        for (int r = 0; r < 15; r++) begin
            cr = tbl[r].cr;
            if (tbl[r].start) pulse_start();
            for (int f = 0; f < tbl[r].frames; f++) frame(tbl[r].hit, tbl[r].cr);
            check_a($sformatf("row%0d", r), tbl[r].st, tbl[r].lv, tbl[r].sc, tbl[r].fc, int'(tbl[r].inv));
        end

        // Finish tie on B: lethal hit on the last frame wins over finishing.
        do_reset();
        pulse_start();
        for (int f = 0; f < 4; f++) frame(1'b0, 4'h0);
        frame(1'b1, 4'h0);
        check("tie_hit.state", int'(st_b), 2);
        check("tie_hit.dead", int'(dead_b), 1);
        check("tie_hit.finished", int'(fin_b), 0);
        check("tie_hit.frame", int'(fc_b), 5);

        do_reset();
        pulse_start();
        for (int f = 0; f < 5; f++) frame(1'b0, 4'h0);
        check("tie_clean.state", int'(st_b), 3);
        check("tie_clean.finished", int'(fin_b), 1);
        check("tie_clean.lives", int'(lv_b), 1);
        frame(1'b0, 4'h0);
        check("tie_clean.frame_frozen", int'(fc_b), 5);

        // Score saturation on C (cap 13).
        do_reset();
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            frame(1'b0, 4'b1111);
            frame(1'b0, 4'b0000);
        end
        check("sat.below_cap", int'(sc_c), 12);
        frame(1'b0, 4'b0101);
        check("sat.capped", int'(sc_c), 13);
        frame(1'b0, 4'b0000);
        frame(1'b0, 4'b1010);
        check("sat.no_wrap", int'(sc_c), 13);

        // Reset coincident with a frame edge mid-game on A, then a clean restart.
        do_reset();
        pulse_start();
        for (int f = 0; f < 3; f++) frame(1'b0, 4'b0101);
        check("midrst.pre_score", int'(sc_a), 2);
        vs = 1'b0;
        step();
        vs = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        check_a("midrst", 0, 3, 0, 0, 0);
        step();
        pulse_start();
        check_a("restart", 1, 3, 0, 0, 0);
        frame(1'b0, 4'b0101);
        check_a("restart.frame1", 1, 3, 0, 1, 0);

        // Randomised stimulus against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst   = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 2) == 0) vs = ~vs;
            de    = ($urandom_range(0, 1) == 1);
            ph    = ($urandom_range(0, 3) == 0);
            obs   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            if ($urandom_range(0, 7) == 0) cr = 4'($urandom_range(0, 15));
            start = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
